// File: rtl/pipelined_rca.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_rca
// Brief    : Pipelined ripple-carry add/subtract; one SEG-bit segment per stage.
// Revision : 1.0
// ============================================================================
module pipelined_rca #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG;

    // Returns {carry into segment MSB, segment carry-out, segment sum}.
    function automatic logic [SEG+1:0] ripple_seg(
        input logic [SEG-1:0] x,
        input logic [SEG-1:0] y,
        input logic           ci
    );
        logic [SEG-1:0] v_sum;
        logic           v_c;
        logic           v_cmsb;
        v_sum  = '0;
        v_c    = ci;
        v_cmsb = ci;
        for (int k = 0; k < SEG; k++) begin
            v_cmsb   = v_c;
            v_sum[k] = x[k] ^ y[k] ^ v_c;
            v_c      = (x[k] & y[k]) | (v_c & (x[k] ^ y[k]));
        end
        return {v_cmsb, v_c, v_sum};
    endfunction

    logic             w_advance;

    // Operand capture register: holds a, b_eff and c0 ahead of stage 0.
    logic             r_in_vld;
    logic [WIDTH-1:0] r_in_a;
    logic [WIDTH-1:0] r_in_b;
    logic             r_in_c;

    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic             r_c   [STAGES];
    logic             r_ovf;

    logic             w_vld_in  [STAGES];
    logic [WIDTH-1:0] w_a_in    [STAGES];
    logic [WIDTH-1:0] w_b_in    [STAGES];
    logic [WIDTH-1:0] w_sum_in  [STAGES];
    logic             w_c_in    [STAGES];
    logic [SEG+1:0]   w_res     [STAGES];
    logic [WIDTH-1:0] w_sum_nxt [STAGES];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam logic [WIDTH-1:0] c_seg_mask = WIDTH'({SEG{1'b1}}) << (s * SEG);

        if (s == 0) begin : g_head
            assign w_vld_in[s] = r_in_vld;
            assign w_a_in[s]   = r_in_a;
            assign w_b_in[s]   = r_in_b;
            assign w_c_in[s]   = r_in_c;
            assign w_sum_in[s] = '0;
        end else begin : g_body
            assign w_vld_in[s] = r_vld[s-1];
            assign w_a_in[s]   = r_a[s-1];
            assign w_b_in[s]   = r_b[s-1];
            assign w_c_in[s]   = r_c[s-1];
            assign w_sum_in[s] = r_sum[s-1];
        end

        assign w_res[s] = ripple_seg(w_a_in[s][s*SEG +: SEG],
                                     w_b_in[s][s*SEG +: SEG],
                                     w_c_in[s]);

        // Lower segments pass through untouched; this stage fills in segment s.
        assign w_sum_nxt[s] = (w_sum_in[s] & ~c_seg_mask)
                            | (WIDTH'(w_res[s][SEG-1:0]) << (s * SEG));
    end

    // One global enable: the whole pipe moves only when the output slot frees up.
    assign w_advance = !r_vld[STAGES-1] || out_ready;
    assign in_ready  = w_advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_vld <= 1'b0;
            r_in_a   <= '0;
            r_in_b   <= '0;
            r_in_c   <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                r_vld[s] <= 1'b0;
                r_a[s]   <= '0;
                r_b[s]   <= '0;
                r_sum[s] <= '0;
                r_c[s]   <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_advance) begin
            r_in_vld <= in_valid;
            if (in_valid) begin
                r_in_a <= a;
                r_in_b <= b ^ {WIDTH{sub}};
                r_in_c <= cin ^ sub;
            end
            // Data only loads behind a valid bundle, so bubbles leave the outputs untouched.
            for (int s = 0; s < STAGES; s++) begin
                r_vld[s] <= w_vld_in[s];
                if (w_vld_in[s]) begin
                    r_a[s]   <= w_a_in[s];
                    r_b[s]   <= w_b_in[s];
                    r_sum[s] <= w_sum_nxt[s];
                    r_c[s]   <= w_res[s][SEG];
                end
            end
            if (w_vld_in[STAGES-1]) begin
                r_ovf <= w_res[STAGES-1][SEG+1] ^ w_res[STAGES-1][SEG];
            end
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign sum       = r_sum[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_rca.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_rca
// Brief    : Directed-vector bench for pipelined_rca at WIDTH=16, SEG=4.
// Revision : 1.0
// ============================================================================
module tb_pipelined_rca;

    localparam int WIDTH  = 16;
    localparam int SEG    = 4;
    localparam int STAGES = WIDTH / SEG;
    localparam int NVEC   = 12;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs [NVEC];

    pipelined_rca #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Single isolated bundle; entered and left at posedge+1.
    task automatic run_one(input int idx, input vec_t v);
        int lat;
        a         = v.a;
        b         = v.b;
        cin       = v.cin;
        sub       = v.sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(STAGES));
        check($sformatf("v%0d sum", idx), 32'(sum), 32'(v.sum));
        check($sformatf("v%0d cout", idx), 32'(cout), 32'(v.cout));
        check($sformatf("v%0d ovf", idx), 32'(ovf), 32'(v.ovf));
        @(posedge clk); #1;
    endtask

    // Eight bundles a=i, b=i<<4 (sum = 17*i); optional output stall once results appear.
    task automatic run_stream(input string tag, input int stall);
        int               sent;
        int               got;
        int               cyc;
        int               stall_left;
        int               first_out;
        int               last_out;
        int               ready_drops;
        int               extra;
        logic [WIDTH-1:0] exp_sum;
        sent = 0; got = 0; cyc = 0; stall_left = stall;
        first_out = -1; last_out = -1; ready_drops = 0;
        cin = 1'b0;
        sub = 1'b0;
        while (got < 8 && cyc < 100) begin
            in_valid = (sent < 8);
            a        = WIDTH'(sent + 1);
            b        = WIDTH'((sent + 1) << 4);
            if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            exp_sum = WIDTH'(17 * (got + 1));
            if (!out_ready) begin
                check($sformatf("%s stall in_ready c%0d", tag, cyc), 32'(in_ready), 32'd0);
                check($sformatf("%s stall hold c%0d", tag, cyc),
                      32'({cout, ovf, sum}), 32'({2'b00, exp_sum}));
            end else if (in_valid && !in_ready) begin
                ready_drops++;
            end
            if (out_valid && out_ready) begin
                check($sformatf("%s result %0d", tag, got + 1),
                      32'({cout, ovf, sum}), 32'({2'b00, exp_sum}));
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check($sformatf("%s result count", tag), 32'(got), 32'd8);
        if (stall == 0) begin
            check($sformatf("%s in_ready drops", tag), 32'(ready_drops), 32'd0);
            check($sformatf("%s output span", tag), 32'(last_out - first_out), 32'd7);
        end
        extra = 0;
        repeat (8) begin
            #1;
            if (out_valid) extra++;
            @(posedge clk); #1;
        end
        check($sformatf("%s extra results", tag), 32'(extra), 32'd0);
    endtask

    initial begin
        //          a         b         cin   sub   sum       cout  ovf
        vecs[0]  = '{16'h00AF, 16'h0051, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[6]  = '{16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0};
        vecs[7]  = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
        vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[9]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[11] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) run_one(i, vecs[i]);

        run_stream("stream", 0);
        run_stream("stall", 3);

        // Three bundles in flight, output stalled, then asynchronous reset.
        begin
            int w;
            int stale;
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                in_valid = 1'b1;
                a        = WIDTH'(16'h0101 * (i + 1));
                b        = 16'h0011;
                #1;
                check($sformatf("inflight %0d in_ready", i), 32'(in_ready), 32'd1);
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            w = 0;
            while (!out_valid && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            check("inflight reached output", 32'(out_valid), 32'd1);
            #2 rst_n = 1'b0;
            #1;
            check("async reset out_valid", 32'(out_valid), 32'd0);
            check("async reset sum", 32'(sum), 32'd0);
            check("async reset cout", 32'(cout), 32'd0);
            check("async reset ovf", 32'(ovf), 32'd0);
            @(posedge clk); #3;
            rst_n     = 1'b1;
            out_ready = 1'b1;
            @(posedge clk); #1;
            check("release in_ready", 32'(in_ready), 32'd1);
            run_one(100, vecs[5]);
            stale = 0;
            repeat (10) begin
                #1;
                if (out_valid) stale++;
                @(posedge clk); #1;
            end
            check("no stale results", 32'(stale), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d errors, required normal completion", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
